// File: rtl/br_regfile_alu.sv
// 32 x DATA_W register bank with a combinational ALU, driven by one 20-bit control word.
// Optional feature: define BR_ZERO_REG_EN to hardwire register 0 to zero.
module br_regfile_alu #(
  parameter int DATA_W    = 32,
  parameter int INIT_BASE = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [19:0]       bus,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] alu_y,
  output logic              wr_en,
  output logic              zero
);

  typedef enum logic [4:0] {
    OP_NOP = 5'b00000,
    OP_ADD = 5'b00001,
    OP_AND = 5'b00010,
    OP_OR  = 5'b00011,
    OP_GT  = 5'b00100,
    OP_SUB = 5'b00101
  } op_e;

  logic [4:0] op;
  logic [4:0] ar2;
  logic [4:0] ar1;
  logic [4:0] aw;

  assign op  = bus[19:15];
  assign ar2 = bus[14:10];
  assign ar1 = bus[9:5];
  assign aw  = bus[4:0];

  logic [DATA_W-1:0] regs_q [32];
  logic              wr_ok;

`ifdef BR_ZERO_REG_EN
  // Register 0 reads as zero regardless of what its storage holds.
  assign rd1   = (ar1 == 5'd0) ? '0 : regs_q[ar1];
  assign rd2   = (ar2 == 5'd0) ? '0 : regs_q[ar2];
  assign wr_ok = wr_en && (aw != 5'd0);
`else
  assign rd1   = regs_q[ar1];
  assign rd2   = regs_q[ar2];
  assign wr_ok = wr_en;
`endif

  always_comb begin
    alu_y = '0;
    wr_en = 1'b1;
    case (op)
      OP_ADD:  alu_y = rd1 + rd2;
      OP_AND:  alu_y = rd1 & rd2;
      OP_OR:   alu_y = rd1 | rd2;
      OP_GT:   alu_y = {{(DATA_W-1){1'b0}}, (rd1 > rd2)};
      OP_SUB:  alu_y = rd1 - rd2;
      default: wr_en = 1'b0;
    endcase
  end

  assign zero = (alu_y == '0);

  // Reads are taken from state, so a same-edge write naturally uses old operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= DATA_W'(INIT_BASE + i);
      end
    end else if (wr_ok) begin
      regs_q[aw] <= alu_y;
    end
  end

endmodule

// File: tb/tb_br_regfile_alu.sv
// Self-checking bench for br_regfile_alu: directed scenarios plus randomized control words
// compared against an array-based reference model.
module tb_br_regfile_alu;

  localparam int DATA_W    = 32;
  localparam int INIT_BASE = 5;

  logic              clk;
  logic              rst_n;
  logic [19:0]       bus;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] alu_y;
  logic              wr_en;
  logic              zero;

  br_regfile_alu #(.DATA_W(DATA_W), .INIT_BASE(INIT_BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .rd1   (rd1),
    .rd2   (rd2),
    .alu_y (alu_y),
    .wr_en (wr_en),
    .zero  (zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] model [32];
  logic [DATA_W-1:0] last_y;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs,
                          input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = DATA_W'(INIT_BASE + i);
  endtask

  function automatic logic [DATA_W-1:0] ref_alu(input logic [4:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    longint unsigned la, lb, m;
    la = a;
    lb = b;
    m  = 64'd1 << DATA_W;
    case (op)
      5'd1:    return DATA_W'((la + lb) % m);
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return (la > lb) ? 1 : 0;
      5'd5:    return DATA_W'((la + m - lb) % m);
      default: return 0;
    endcase
  endfunction

  function automatic logic [19:0] mk(input int op, input int ar2, input int ar1, input int aw);
    return {5'(op), 5'(ar2), 5'(ar1), 5'(aw)};
  endfunction

  // driver: called just after a rising edge; checks before the next edge, then advances
  task automatic do_op(input logic [19:0] b);
    logic [4:0] op, a2, a1, aw;
    logic [DATA_W-1:0] ey;
    logic ewr;
    op = b[19:15]; a2 = b[14:10]; a1 = b[9:5]; aw = b[4:0];
    bus = b;
    ey  = ref_alu(op, model[a1], model[a2]);
    ewr = (op >= 5'd1 && op <= 5'd5);
    @(negedge clk);
    check_eq("rd1", rd1, model[a1]);
    check_eq("rd2", rd2, model[a2]);
    check_eq("alu_y", alu_y, ey);
    check_eq("wr_en", DATA_W'(wr_en), DATA_W'(ewr));
    check_eq("zero", DATA_W'(zero), DATA_W'(ey == 0));
    last_y = alu_y;
    @(posedge clk);
    #1;
    if (ewr && rst_n) model[aw] = ey;
  endtask

  task automatic peek(input string tag, input int idx, input logic [DATA_W-1:0] exp);
    bus = mk(0, 0, idx, 0);
    @(negedge clk);
    check_eq(tag, rd1, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus   = '0;
    model_reset();
    @(posedge clk); #1;
    peek("rst_reg0", 0, 5);
    peek("rst_reg31", 31, 36);
    peek("rst_reg17", 17, 22);
    rst_n = 1'b1;

    do_op(mk(1, 0, 0, 31));
    check_eq("tp_add_y", last_y, 10);
    peek("tp_reg31", 31, 10);

    do_op(mk(1, 0, 1, 7));
    check_eq("tp_add7_y", last_y, 11);
    do_op(mk(0, 0, 0, 7));
    peek("tp_reg7_nop", 7, 11);

    do_op(mk(2, 2, 3, 2));
    check_eq("tp_and_y", last_y, 0);
    peek("tp_reg2", 2, 0);
    do_op(mk(4, 1, 3, 4));
    check_eq("tp_gt_y", last_y, 1);
    peek("tp_reg4", 4, 1);

    do_op(mk(5, 1, 0, 9));
    check_eq("tp_sub_y", last_y, 32'hFFFF_FFFF);
    peek("tp_reg9", 9, 32'hFFFF_FFFF);
    do_op(mk(1, 0, 9, 11));
    check_eq("tp_carry_y", last_y, 4);

    do_op(mk(31, 3, 3, 10));
    check_eq("tp_inv_y", last_y, 0);
    peek("tp_reg10", 10, 15);
    do_op(mk(1, 5, 5, 5));
    peek("tp_reg5_self", 5, 20);

    // randomized control words
    for (int n = 0; n < 400; n++) begin
      int op;
      op = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 31) : $urandom_range(0, 5);
      do_op(mk(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31)));
    end

    // reset mid-cycle while an ADD to reg7 is pending
    bus = mk(1, 0, 1, 7);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_async_rd1", rd1, 6);
    check_eq("rst_async_y", alu_y, 11);
    for (int i = 0; i < 32; i++) peek($sformatf("rst_reg%0d", i), i, model[i]);
    bus = mk(1, 0, 1, 7);
    @(posedge clk); #1;
    peek("rst_hold_reg7", 7, 12);
    rst_n = 1'b1;
    do_op(mk(1, 0, 1, 7));
    peek("post_rst_reg7", 7, 11);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/br_regfile_alu.md
Name: br_regfile_alu

Overview:
- 32-entry x 32-bit register bank with a combinational ALU, driven by a single 20-bit control word.
- Each cycle it reads two registers (AR1, AR2), applies the opcode and writes the result back to register AW on the rising clock edge.
- Serves as the datapath core (register file plus execute stage) of the course CPU.

Parameters:
- DATA_W, 32, register and ALU data width.
- INIT_BASE, 5, reset value of register i is INIT_BASE + i, truncated to DATA_W.

Ports:
- clk  input  1  system clock; all writes happen on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bus  input  20  control word: [19:15] OP, [14:10] AR2, [9:5] AR1, [4:0] AW.
- rd1  output  DATA_W  combinational contents of register AR1.
- rd2  output  DATA_W  combinational contents of register AR2.
- alu_y  output  DATA_W  combinational ALU result.
- wr_en  output  1  high when OP is a valid opcode (a write will occur at the next edge).
- zero  output  1  high when alu_y == 0.

Behaviour:
- Reset: rst_n low asynchronously loads every register i with INIT_BASE + i (reg0=5 … reg31=36). Outputs are combinational from the registers, so under reset rd1/rd2/alu_y reflect the reset contents. Reset overrides any write in progress: a write on the same edge as rst_n low is discarded.
- Reads: rd1 = reg[AR1], rd2 = reg[AR2]. Zero latency; a register written at edge N is visible on rd1/rd2 immediately after edge N. No write-through bypass of same-cycle data is needed, because reads are combinational from state.
- Opcodes (A = rd1, B = rd2):
  - 00001 ADD: A + B, modulo 2^DATA_W, carry discarded.
  - 00010 AND: A & B.
  - 00011 OR: A | B.
  - 00100 GT: 1 if A > B unsigned, else 0 (zero-extended).
  - 00101 SUB: A - B, modulo 2^DATA_W.
  - Any other OP (including 00000): NOP. alu_y = 0, wr_en = 0, no register changes.
- Write: on the posedge clk with rst_n high and wr_en = 1, reg[AW] <= alu_y. Every register, including reg0, is writable.
- AW may equal AR1 or AR2. The old value is used and the new value lands at the edge (read-before-write).
- The bus is sampled only at the clock edge for the write. It may change freely between edges.
- zero = (alu_y == 0), independent of wr_en.

Optional Feature:
- Macro BR_ZERO_REG_EN.
- Defined: register 0 is hardwired. It reads as 0 at all times, including reset, and writes with AW = 0 are ignored. wr_en still reports valid opcodes.
- Not defined: register 0 behaves like any other register (reset value INIT_BASE).
- All Test Plan values assume the macro is undefined.

Test Plan:
- Reset then bus=00001_00000_00000_11111, one clk -> alu_y=10 before the edge; reg31=10 after (check via AR1=31, rd1=10).
- ADD AR1=1 (6), AR2=0 (5), AW=7, one clk -> alu_y=11, reg7 becomes 11 (was 12); NOP op 00000 on the next cycle leaves reg7=11.
- AND AR1=3 (8), AR2=2 (7), AW=2 -> alu_y=0, zero=1, reg2 becomes 0. Then GT AR1=3 (8), AR2=1 (6), AW=4 -> alu_y=1, reg4=1.
- SUB AR1=0 (5), AR2=1 (6), AW=9 -> alu_y=0xFFFFFFFF (wrap), reg9=0xFFFFFFFF. Then ADD AR1=9, AR2=0 -> alu_y=4 (carry dropped).
- Invalid OP 11111 with AW=10 -> wr_en=0, alu_y=0, reg10 stays 15. Self-update ADD AR1=AR2=AW=5 (10) -> reg5=20 after one edge.
- Assert rst_n low mid-cycle while an ADD to AW=7 is pending -> all registers return to INIT_BASE+i immediately, with no write at the next edge while reset is held.
